// File: rtl/signed_restoring_divider.sv
// -----------------------------------------------------------------------------
// signed_restoring_divider
//
// Sequential signed integer divider built on the radix-2 restoring algorithm.
// It produces one quotient bit per clock. The results follow Verilog signed
// '/' and '%': the quotient truncates toward zero, and the remainder takes the
// sign of the dividend.
//
// Parameters
//   nb            operand / result width in bits (nb >= 2)
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous reset, active-high
//   start         one-cycle request; A and B are sampled on the same edge
//   A             signed dividend
//   B             signed divisor
//   Quotient      signed quotient, registered
//   Remainder     signed remainder, registered
//   busy          high while a division is in flight
//   done          one-cycle pulse; results are valid from this cycle on
//   div_by_zero   registered with the results; set when B == 0
//
// Build option
//   DIV_ZERO_FAST_EN  when defined, a zero divisor skips the iterations and
//                     finishes 2 edges after start instead of nb+2.
//
// State table
//   IDLE | waiting for start; outputs hold the last result
//   RUN  | nb shift / trial-subtract iterations
//   FIX  | sign correction, load outputs, pulse done
// -----------------------------------------------------------------------------
module signed_restoring_divider #(
    parameter int nb = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [nb-1:0] A,
    input  logic signed [nb-1:0] B,
    output logic signed [nb-1:0] Quotient,
    output logic signed [nb-1:0] Remainder,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero
);

    localparam int cw = $clog2(nb) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t        state;
    logic [nb-1:0] mag_a;
    logic [nb-1:0] mag_b;
    logic          neg_a;
    logic          neg_q;
    logic          b_zero;
    logic [nb:0]   rem;
    logic [nb-1:0] quo;
    logic [cw-1:0] cnt;

    logic [nb-1:0] a_u;
    logic [nb-1:0] b_u;
    logic [nb-1:0] a_abs;
    logic [nb-1:0] b_abs;
    logic [nb:0]   rem_sh;
    logic [nb:0]   diff;

    // The magnitude of -2^(nb-1) is 2^(nb-1). It still fits, because the
    // magnitudes are treated as unsigned.
    assign a_u   = A;
    assign b_u   = B;
    assign a_abs = A[nb-1] ? -a_u : a_u;
    assign b_abs = B[nb-1] ? -b_u : b_u;

    // The partial remainder always stays below 2*|B| <= 2^nb, so nb+1 bits
    // is enough. The top bit of the trial difference is its sign.
    assign rem_sh = {rem[nb-1:0], quo[nb-1]};
    assign diff   = rem_sh - {1'b0, mag_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mag_a       <= '0;
            mag_b       <= '0;
            neg_a       <= 1'b0;
            neg_q       <= 1'b0;
            b_zero      <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            Quotient    <= '0;
            Remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a  <= a_abs;
                        mag_b  <= b_abs;
                        neg_a  <= A[nb-1];
                        neg_q  <= A[nb-1] ^ B[nb-1];
                        b_zero <= (B == '0);
                        rem    <= '0;
                        quo    <= a_abs;
                        cnt    <= cw'(nb - 1);
                        busy   <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
                        state  <= (B == '0) ? FIX : RUN;
`else
                        state  <= RUN;
`endif
                    end
                end

                RUN: begin
                    if (!diff[nb]) begin
                        rem <= diff;
                        quo <= {quo[nb-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh;
                        quo <= {quo[nb-2:0], 1'b0};
                    end
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - cw'(1);
                    end
                end

                FIX: begin
                    // The zero-divisor results are fixed values, so the fast
                    // path never needs the iterated state.
                    if (b_zero) begin
                        Quotient  <= '1;
                        Remainder <= neg_a ? -mag_a : mag_a;
                    end else begin
                        Quotient  <= neg_q ? -quo : quo;
                        Remainder <= neg_a ? -rem[nb-1:0] : rem[nb-1:0];
                    end
                    div_by_zero <= b_zero;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_restoring_divider.sv
module tb_signed_restoring_divider;

    localparam int nb = 12;

`ifdef DIV_ZERO_FAST_EN
    localparam int dz_lat = 2;
`else
    localparam int dz_lat = nb + 2;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic signed [nb-1:0] a_in = '0;
    logic signed [nb-1:0] b_in = '0;
    logic [nb-1:0]        q_out;
    logic [nb-1:0]        r_out;
    logic                 busy;
    logic                 done;
    logic                 dz;

    int n_checks = 0;
    int n_pass   = 0;

    signed_restoring_divider #(.nb(nb)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (a_in),
        .B           (b_in),
        .Quotient    (q_out),
        .Remainder   (r_out),
        .busy        (busy),
        .done        (done),
        .div_by_zero (dz)
    );

    always #5 clk = ~clk;

    function automatic logic [nb-1:0] w12(input int v);
        return v[nb-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Called at #1 after an edge. The start is sampled at the next edge (E0).
    task automatic launch(input logic signed [nb-1:0] a, input logic signed [nb-1:0] b);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk); #1;
        start = 1'b0;
        a_in  = 'x;
        b_in  = 'x;
    endtask

    // Counts the edges after E0 until done is seen. The count is 99 on timeout.
    task automatic wait_done(output int lat);
        lat = 99;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_div(input string tag, input int a, input int b,
                           input int eq, input int er, input int edz, input int elat);
        int lat;
        launch(a[nb-1:0], b[nb-1:0]);
        wait_done(lat);
        chk({tag, "_lat"}, lat + 1, elat);
        chk({tag, "_q"}, q_out, w12(eq));
        chk({tag, "_r"}, r_out, w12(er));
        chk({tag, "_dz"}, dz, edz);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int lat;
        int dcount;
        logic signed [nb-1:0] pa, pb;
        int ai, bi;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", q_out, 0);
        chk("rst_r", r_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", dz, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic case, with busy checked right after acceptance.
        launch(12'sd100, 12'sd7);
        chk("t1_busy_run", busy, 1);
        wait_done(lat);
        chk("t1_lat", lat + 1, nb + 2);
        chk("t1_q", q_out, w12(14));
        chk("t1_r", r_out, w12(2));
        chk("t1_dz", dz, 0);
        @(posedge clk); #1;
        chk("t1_done_pulse", done, 0);
        chk("t1_hold_q", q_out, w12(14));

        run_div("neg_a",  -100,  7, -14, -2, 0, nb + 2);
        run_div("neg_b",   100, -7, -14,  2, 0, nb + 2);
        run_div("neg_ab", -100, -7,  14, -2, 0, nb + 2);
        run_div("min_m1", -2048, -1, -2048, 0, 0, nb + 2);
        run_div("min_max", -2048, 2047, -1, -1, 0, nb + 2);
        run_div("min_2",  -2048,  2, -1024, 0, 0, nb + 2);
        run_div("small",     3, 10,   0,  3, 0, nb + 2);
        run_div("dz_pos",    5,  0,  -1,  5, 1, dz_lat);
        run_div("dz_neg",   -5,  0,  -1, -5, 1, dz_lat);
        run_div("after_dz", 100, 7,  14,  2, 0, nb + 2);

        // A start while busy is ignored.
        launch(12'sd50, 12'sd6);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; a_in = 12'sd1; b_in = 12'sd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        chk("ign_lat", lat + 4, nb + 2);
        chk("ign_q", q_out, w12(8));
        chk("ign_r", r_out, w12(2));
        @(posedge clk); #1;
        chk("ign_busy_after", busy, 0);

        // A reset at iteration 6 aborts the division, and a start issued
        // together with the reset is dropped.
        launch(12'sd100, 12'sd7);
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        start = 1'b1; a_in = 12'sd9; b_in = 12'sd3;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        chk("abort_q", q_out, 0);
        chk("abort_r", r_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_dz", dz, 0);
        dcount = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) dcount++;
        end
        chk("abort_no_activity", dcount, 0);
        run_div("post_rst", -77, 5, -15, -2, 0, nb + 2);

        // Random operands, each start issued back-to-back on the done cycle.
        pa = $urandom;
        do pb = $urandom; while (pb == '0);
        launch(pa, pb);
        for (int i = 0; i < 1000; i++) begin
            wait_done(lat);
            ai = pa;
            bi = pb;
            chk("rnd_lat", lat + 1, nb + 2);
            chk("rnd_q", q_out, w12(ai / bi));
            chk("rnd_r", r_out, w12(ai % bi));
            if (i < 999) begin
                pa = $urandom;
                do pb = $urandom; while (pb == '0);
                launch(pa, pb);
            end
        end
        @(posedge clk); #1;
        chk("rnd_done_end", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
